// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: turns EX/MEM entries into data-memory transactions and
// fills the MEM/WB registers. Define MEM_ACCESS_MISALIGN_TRAP_EN to trap misaligned accesses.
module mem_access_stage #(
  parameter int ADDR_W = 32,
  parameter int RA_W   = 5,
  parameter int TMO    = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic              RegWrite_i,
  input  logic              MemToReg_i,
  input  logic [1:0]        MemRead_i,
  input  logic [1:0]        MemWrite_i,
  input  logic              LoadUnsigned_i,
  input  logic [31:0]       WriteData_i,
  input  logic [ADDR_W-1:0] ALUdata_i,
  input  logic [RA_W-1:0]   RegAddr_i,
  output logic              stall_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [3:0]        dmem_be_o,
  output logic [31:0]       dmem_wdata_o,
  input  logic [31:0]       dmem_rdata_i,
  input  logic              dmem_ack_i,
  output logic              valid_o,
  output logic              RegWrite_o,
  output logic              MemToReg_o,
  output logic [31:0]       ReadData_o,
  output logic [ADDR_W-1:0] ALUdata_o,
  output logic [RA_W-1:0]   RegAddr_o,
  output logic              err_o
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

  // Latched request
  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [1:0]          code_q, code_d;
  logic [1:0]          off_q, off_d;
  logic [3:0]          be_q, be_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                uns_q, uns_d;
  logic                rw_q, rw_d;
  logic                mtr_q, mtr_d;
  logic [ADDR_W-1:0]   alu_q, alu_d;
  logic [RA_W-1:0]     ra_q, ra_d;

  // MEM/WB registers
  logic                out_valid_q, out_valid_d;
  logic                out_rw_q, out_rw_d;
  logic                out_mtr_q, out_mtr_d;
  logic [31:0]         out_rdata_q, out_rdata_d;
  logic [ADDR_W-1:0]   out_alu_q, out_alu_d;
  logic [RA_W-1:0]     out_ra_q, out_ra_d;
  logic                err_q, err_d;

  // Incoming request decode
  logic [1:0]  code_in;
  logic        we_in;
  logic [1:0]  a_lo;
  logic [1:0]  off_in;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;
  logic        trap_in;
  logic        start;
  logic [31:0] lane_data;
  logic [31:0] load_data;

  always_comb begin
    code_in  = (MemWrite_i != 2'd0) ? MemWrite_i : MemRead_i;
    we_in    = (MemWrite_i != 2'd0);
    a_lo     = ALUdata_i[1:0];
    off_in   = 2'd0;
    be_in    = 4'b1111;
    wdata_in = WriteData_i;
    case (code_in)
      2'd1: begin
        off_in   = a_lo;
        be_in    = 4'b0001 << a_lo;
        wdata_in = {4{WriteData_i[7:0]}};
      end
      2'd2: begin
        off_in   = {a_lo[1], 1'b0};
        be_in    = a_lo[1] ? 4'b1100 : 4'b0011;
        wdata_in = {2{WriteData_i[15:0]}};
      end
      default: ;
    endcase
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    trap_in = (state_q == S_IDLE) && valid_i &&
              (((code_in == 2'd2) && a_lo[0]) || ((code_in == 2'd3) && (a_lo != 2'd0)));
`else
    trap_in = 1'b0;
`endif
    start = (state_q == S_IDLE) && valid_i && (code_in != 2'd0) && !trap_in;
  end

  // Bus outputs come straight from the inputs in the issue cycle, then from the latch
  always_comb begin
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    dmem_addr_o  = '0;
    dmem_be_o    = 4'b0000;
    dmem_wdata_o = 32'd0;
    if (state_q == S_WAIT) begin
      dmem_req_o   = 1'b1;
      dmem_we_o    = we_q;
      dmem_addr_o  = {alu_q[ADDR_W-1:2], 2'b00};
      dmem_be_o    = be_q;
      dmem_wdata_o = wdata_q;
    end else if (start) begin
      dmem_req_o   = 1'b1;
      dmem_we_o    = we_in;
      dmem_addr_o  = {ALUdata_i[ADDR_W-1:2], 2'b00};
      dmem_be_o    = be_in;
      dmem_wdata_o = wdata_in;
    end
    stall_o = start || ((state_q == S_WAIT) && !dmem_ack_i);
  end

  always_comb begin
    lane_data = dmem_rdata_i >> {off_q, 3'b000};
    case (code_q)
      2'd1:    load_data = uns_q ? {24'd0, lane_data[7:0]} : {{24{lane_data[7]}}, lane_data[7:0]};
      2'd2:    load_data = uns_q ? {16'd0, lane_data[15:0]} : {{16{lane_data[15]}}, lane_data[15:0]};
      default: load_data = dmem_rdata_i;
    endcase
    if (we_q) load_data = 32'd0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    code_d  = code_q;
    off_d   = off_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    uns_d   = uns_q;
    rw_d    = rw_q;
    mtr_d   = mtr_q;
    alu_d   = alu_q;
    ra_d    = ra_q;
    // MEM/WB default is a bubble
    out_valid_d = 1'b0;
    out_rw_d    = 1'b0;
    out_mtr_d   = 1'b0;
    out_rdata_d = 32'd0;
    out_alu_d   = '0;
    out_ra_d    = '0;
    err_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trap_in) begin
          out_valid_d = 1'b1;
          out_mtr_d   = MemToReg_i;
          out_alu_d   = ALUdata_i;
          out_ra_d    = RegAddr_i;
          err_d       = 1'b1;
        end else if (start) begin
          state_d = S_WAIT;
          cnt_d   = 8'd0;
          we_d    = we_in;
          code_d  = code_in;
          off_d   = off_in;
          be_d    = be_in;
          wdata_d = wdata_in;
          uns_d   = LoadUnsigned_i;
          rw_d    = RegWrite_i;
          mtr_d   = MemToReg_i;
          alu_d   = ALUdata_i;
          ra_d    = RegAddr_i;
        end else begin
          out_valid_d = valid_i;
          out_rw_d    = RegWrite_i;
          out_mtr_d   = MemToReg_i;
          out_alu_d   = ALUdata_i;
          out_ra_d    = RegAddr_i;
        end
      end
      S_WAIT: begin
        if (dmem_ack_i) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b1;
          out_rw_d    = rw_q;
          out_mtr_d   = mtr_q;
          out_rdata_d = load_data;
          out_alu_d   = alu_q;
          out_ra_d    = ra_q;
        end else if (cnt_q == TMO_LAST) begin
          // Timed out: retire the entry without a register write
          state_d     = S_IDLE;
          out_valid_d = 1'b1;
          out_mtr_d   = mtr_q;
          out_alu_d   = alu_q;
          out_ra_d    = ra_q;
          err_d       = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      we_q        <= 1'b0;
      code_q      <= 2'd0;
      off_q       <= 2'd0;
      be_q        <= 4'd0;
      wdata_q     <= 32'd0;
      uns_q       <= 1'b0;
      rw_q        <= 1'b0;
      mtr_q       <= 1'b0;
      alu_q       <= '0;
      ra_q        <= '0;
      out_valid_q <= 1'b0;
      out_rw_q    <= 1'b0;
      out_mtr_q   <= 1'b0;
      out_rdata_q <= 32'd0;
      out_alu_q   <= '0;
      out_ra_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      code_q      <= code_d;
      off_q       <= off_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      uns_q       <= uns_d;
      rw_q        <= rw_d;
      mtr_q       <= mtr_d;
      alu_q       <= alu_d;
      ra_q        <= ra_d;
      out_valid_q <= out_valid_d;
      out_rw_q    <= out_rw_d;
      out_mtr_q   <= out_mtr_d;
      out_rdata_q <= out_rdata_d;
      out_alu_q   <= out_alu_d;
      out_ra_q    <= out_ra_d;
      err_q       <= err_d;
    end
  end

  assign valid_o    = out_valid_q;
  assign RegWrite_o = out_rw_q;
  assign MemToReg_o = out_mtr_q;
  assign ReadData_o = out_rdata_q;
  assign ALUdata_o  = out_alu_q;
  assign RegAddr_o  = out_ra_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage (TMO=4); expectations follow MEM_ACCESS_MISALIGN_TRAP_EN.
module tb_mem_access_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i, RegWrite_i, MemToReg_i, LoadUnsigned_i;
  logic [1:0]  MemRead_i, MemWrite_i;
  logic [31:0] WriteData_i, ALUdata_i;
  logic [4:0]  RegAddr_i;
  logic        stall_o, dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
  logic [3:0]  dmem_be_o;
  logic        dmem_ack_i;
  logic        valid_o, RegWrite_o, MemToReg_o, err_o;
  logic [31:0] ReadData_o, ALUdata_o;
  logic [4:0]  RegAddr_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        rw;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [4:0]  ra;
  } exp_t;
  exp_t sb[$];

  always #5 clk_i = ~clk_i;

  mem_access_stage #(.ADDR_W(32), .RA_W(5), .TMO(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .RegWrite_i(RegWrite_i),
    .MemToReg_i(MemToReg_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .LoadUnsigned_i(LoadUnsigned_i), .WriteData_i(WriteData_i), .ALUdata_i(ALUdata_i),
    .RegAddr_i(RegAddr_i), .stall_o(stall_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_rdata_i(dmem_rdata_i), .dmem_ack_i(dmem_ack_i), .valid_o(valid_o),
    .RegWrite_o(RegWrite_o), .MemToReg_o(MemToReg_o), .ReadData_o(ReadData_o),
    .ALUdata_o(ALUdata_o), .RegAddr_o(RegAddr_o), .err_o(err_o)
  );

  function automatic logic [3:0] m_be(input logic [1:0] code, input logic [1:0] a);
    case (code)
      2'd1:    m_be = 4'b0001 << a;
      2'd2:    m_be = a[1] ? 4'b1100 : 4'b0011;
      default: m_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] code, input logic [31:0] wd);
    case (code)
      2'd1:    m_wdata = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
      2'd2:    m_wdata = {wd[15:0], wd[15:0]};
      default: m_wdata = wd;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] code, input logic uns, input logic we,
                                         input logic [1:0] a, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[8*int'(a) +: 8];
    h = a[1] ? rd[31:16] : rd[15:0];
    if (we) m_load = 32'd0;
    else if (code == 2'd1) m_load = uns ? {24'd0, b} : {{24{b[7]}}, b};
    else if (code == 2'd2) m_load = uns ? {16'd0, h} : {{16{h[15]}}, h};
    else m_load = rd;
  endfunction

  task automatic set_idle();
    valid_i = 0; RegWrite_i = 0; MemToReg_i = 0; MemRead_i = 0; MemWrite_i = 0;
    LoadUnsigned_i = 0; WriteData_i = 0; ALUdata_i = 0; RegAddr_i = 0;
  endtask

  task automatic drive(input logic [1:0] rd, input logic [1:0] wr, input logic uns, input logic rw,
                       input logic [31:0] wd, input logic [31:0] addr, input logic [4:0] ra);
    valid_i = 1; RegWrite_i = rw; MemToReg_i = (rd != 0); MemRead_i = rd; MemWrite_i = wr;
    LoadUnsigned_i = uns; WriteData_i = wd; ALUdata_i = addr; RegAddr_i = ra;
  endtask

  // Waits (bounded) for valid_o and compares it with the oldest scoreboard entry
  task automatic wait_out(input string name);
    exp_t e;
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk_i);
      if (valid_o === 1'b1) seen = 1;
    end
    checks++;
    if (!seen || sb.size() == 0) begin
      errors++;
      $display("FAIL %s out_valid: got valid_o=%b, want 1 with pending entry (sb=%0d)", name, valid_o, sb.size());
      if (sb.size() != 0) void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    checks++;
    if (ReadData_o !== e.rdata) begin
      errors++;
      $display("FAIL %s ReadData: got %h want %h", name, ReadData_o, e.rdata);
    end
    checks++;
    if (RegWrite_o !== e.rw || err_o !== e.err) begin
      errors++;
      $display("FAIL %s ctrl: got rw=%b err=%b want rw=%b err=%b", name, RegWrite_o, err_o, e.rw, e.err);
    end
    checks++;
    if (ALUdata_o !== e.alu || RegAddr_o !== e.ra) begin
      errors++;
      $display("FAIL %s passthru: got alu=%h ra=%0d want alu=%h ra=%0d", name, ALUdata_o, RegAddr_o, e.alu, e.ra);
    end
    $display("txn %s: ReadData=%h rw=%b err=%b alu=%h ra=%0d", name, ReadData_o, RegWrite_o, err_o, ALUdata_o, RegAddr_o);
  endtask

  // One complete EX/MEM entry; ack arrives after ack_delay WAIT cycles without it
  task automatic do_op(input string name, input logic [1:0] rd, input logic [1:0] wr, input logic uns,
                       input logic rw, input logic [31:0] wd, input logic [31:0] addr,
                       input logic [4:0] ra, input int ack_delay, input logic [31:0] rdata);
    logic [1:0]  code;
    logic        we;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_be;
    int          stalls;
    code    = (wr != 0) ? wr : rd;
    we      = (wr != 0);
    e_addr  = {addr[31:2], 2'b00};
    e_be    = m_be(code, addr[1:0]);
    e_wdata = m_wdata(code, wd);
    @(posedge clk_i); #1;
    drive(rd, wr, uns, rw, wd, addr, ra);
    if (code == 0) begin
      sb.push_back('{rw, 1'b0, 32'd0, addr, ra});
      @(negedge clk_i);
      checks++;
      if (stall_o !== 1'b0 || dmem_req_o !== 1'b0) begin
        errors++;
        $display("FAIL %s nomem: got stall=%b req=%b want 0 0", name, stall_o, dmem_req_o);
      end
      @(posedge clk_i); #1;
      set_idle();
      wait_out(name);
      return;
    end
    sb.push_back('{rw, 1'b0, m_load(code, uns, we, addr[1:0], rdata), addr, ra});
    @(negedge clk_i);
    stalls = stall_o ? 1 : 0;
    checks++;
    if (dmem_req_o !== 1'b1 || dmem_we_o !== we || dmem_addr_o !== e_addr ||
        dmem_be_o !== e_be || dmem_wdata_o !== e_wdata) begin
      errors++;
      $display("FAIL %s issue: got req=%b we=%b addr=%h be=%b wd=%h want 1 %b %h %b %h",
               name, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o, we, e_addr, e_be, e_wdata);
    end
    @(posedge clk_i); #1;
    set_idle();
    for (int i = 0; i < ack_delay; i++) begin
      @(negedge clk_i);
      if (stall_o) stalls++;
      checks++;
      if (dmem_req_o !== 1'b1 || dmem_we_o !== we || dmem_addr_o !== e_addr ||
          dmem_be_o !== e_be || dmem_wdata_o !== e_wdata) begin
        errors++;
        $display("FAIL %s hold: got req=%b addr=%h be=%b wd=%h want 1 %h %b %h",
                 name, dmem_req_o, dmem_addr_o, dmem_be_o, dmem_wdata_o, e_addr, e_be, e_wdata);
      end
      @(posedge clk_i); #1;
    end
    dmem_ack_i = 1; dmem_rdata_i = rdata;
    @(negedge clk_i);
    checks++;
    if (stall_o !== 1'b0 || stalls != ack_delay + 1) begin
      errors++;
      $display("FAIL %s stall: got ack-cycle stall=%b stall cycles=%0d want 0 %0d", name, stall_o, stalls, ack_delay + 1);
    end
    @(posedge clk_i); #1;
    dmem_ack_i = 0; dmem_rdata_i = 32'h5A5A5A5A;
    wait_out(name);
  endtask

  task automatic test_reset();
    rst_i = 1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if ({valid_o, RegWrite_o, MemToReg_o, err_o, stall_o, dmem_req_o} !== 6'd0 ||
        ReadData_o !== 32'd0 || ALUdata_o !== 32'd0 || RegAddr_o !== 5'd0) begin
      errors++;
      $display("FAIL reset: got valid=%b err=%b stall=%b req=%b rdata=%h alu=%h want all 0",
               valid_o, err_o, stall_o, dmem_req_o, ReadData_o, ALUdata_o);
    end
    $display("txn reset: outputs cleared check done");
    @(posedge clk_i); #1;
    rst_i = 0;
  endtask

  task automatic test_passthrough();
    do_op("pass_alu", 2'd0, 2'd0, 1'b0, 1'b1, 32'h0, 32'h0000_0055, 5'd7, 0, 32'h0);
    do_op("pass_norw", 2'd0, 2'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hA5A5_0003, 5'd31, 0, 32'h0);
  endtask

  task automatic test_loads();
    do_op("word_rd", 2'd3, 2'd0, 1'b0, 1'b1, 32'h0, 32'h0000_0100, 5'd3, 3, 32'hDEADBEEF);
    do_op("byte_s", 2'd1, 2'd0, 1'b0, 1'b1, 32'h0, 32'h0000_0103, 5'd4, 0, 32'h8000_0000);
    do_op("byte_u", 2'd1, 2'd0, 1'b1, 1'b1, 32'h0, 32'h0000_0103, 5'd5, 1, 32'h8000_0000);
    do_op("half_s", 2'd2, 2'd0, 1'b0, 1'b1, 32'h0, 32'h0000_0102, 5'd6, 1, 32'h8001_1234);
    do_op("half_u", 2'd2, 2'd0, 1'b1, 1'b1, 32'h0, 32'h0000_0100, 5'd8, 2, 32'h1234_F00F);
  endtask

  task automatic test_stores();
    do_op("half_st", 2'd0, 2'd2, 1'b0, 1'b0, 32'h1234ABCD, 32'h0000_0102, 5'd0, 2, 32'hFFFF_FFFF);
    do_op("byte_st", 2'd0, 2'd1, 1'b0, 1'b0, 32'h0000_00A5, 32'h0000_0101, 5'd0, 0, 32'h1111_1111);
    do_op("rdwr_st", 2'd3, 2'd1, 1'b0, 1'b1, 32'h0000_0077, 32'h0000_0203, 5'd9, 1, 32'h2222_2222);
  endtask

  task automatic test_misalign();
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    @(posedge clk_i); #1;
    drive(2'd3, 2'd0, 1'b0, 1'b1, 32'h0, 32'h0000_0101, 5'd10);
    sb.push_back('{1'b0, 1'b1, 32'd0, 32'h0000_0101, 5'd10});
    @(negedge clk_i);
    checks++;
    if (dmem_req_o !== 1'b0 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL trap_noreq: got req=%b stall=%b want 0 0", dmem_req_o, stall_o);
    end
    @(posedge clk_i); #1;
    set_idle();
    wait_out("trap_word");
`else
    do_op("align_word", 2'd3, 2'd0, 1'b0, 1'b1, 32'h0, 32'h0000_0101, 5'd10, 1, 32'hCAFEF00D);
    do_op("align_half", 2'd2, 2'd0, 1'b0, 1'b1, 32'h0, 32'h0000_0103, 5'd11, 0, 32'h7FFF_0001);
`endif
  endtask

  task automatic test_timeout();
    int waits = 0;
    bit seen = 0;
    @(posedge clk_i); #1;
    drive(2'd3, 2'd0, 1'b0, 1'b1, 32'h0, 32'h0000_0300, 5'd12);
    sb.push_back('{1'b0, 1'b1, 32'd0, 32'h0000_0300, 5'd12});
    @(posedge clk_i); #1;
    set_idle();
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk_i);
      if (valid_o === 1'b1) seen = 1;
      else if (stall_o) waits++;
    end
    checks++;
    if (!seen || waits != 4 || dmem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout: got seen=%b wait cycles=%0d req=%b want 1 4 0", seen, waits, dmem_req_o);
    end
    if (seen) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (err_o !== e.err || RegWrite_o !== e.rw || ALUdata_o !== e.alu || RegAddr_o !== e.ra) begin
        errors++;
        $display("FAIL timeout_out: got err=%b rw=%b alu=%h ra=%0d want %b %b %h %0d",
                 err_o, RegWrite_o, ALUdata_o, RegAddr_o, e.err, e.rw, e.alu, e.ra);
      end
    end else if (sb.size() != 0) void'(sb.pop_front());
    @(negedge clk_i);
    checks++;
    if (err_o !== 1'b0 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse: got err=%b valid=%b want 0 0", err_o, valid_o);
    end
    $display("txn timeout: wait cycles=%0d", waits);
  endtask

  task automatic test_ack_idle();
    @(posedge clk_i); #1;
    dmem_ack_i = 1; dmem_rdata_i = 32'h1357_9BDF;
    @(negedge clk_i);
    checks++;
    if (stall_o !== 1'b0 || dmem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL ack_idle: got stall=%b req=%b want 0 0", stall_o, dmem_req_o);
    end
    @(posedge clk_i); #1;
    dmem_ack_i = 0;
    @(negedge clk_i);
    checks++;
    if (valid_o !== 1'b0 || ReadData_o !== 32'd0) begin
      errors++;
      $display("FAIL ack_idle_out: got valid=%b rdata=%h want 0 0", valid_o, ReadData_o);
    end
    $display("txn ack_idle: stray ack ignored check done");
  endtask

  task automatic test_reset_mid_wait();
    @(posedge clk_i); #1;
    drive(2'd3, 2'd0, 1'b0, 1'b1, 32'h0, 32'h0000_0200, 5'd13);
    @(posedge clk_i); #1;
    set_idle();
    ALUdata_i = 32'h0000_0200;
    @(negedge clk_i);
    checks++;
    if (dmem_req_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_wait_pre: got req=%b want 1", dmem_req_o);
    end
    @(posedge clk_i); #1;
    rst_i = 1;
    @(posedge clk_i); #1;
    rst_i = 0; dmem_ack_i = 1; dmem_rdata_i = 32'hFEED_FACE;
    @(negedge clk_i);
    checks++;
    if (dmem_req_o !== 1'b0 || stall_o !== 1'b0 || valid_o !== 1'b0 || err_o !== 1'b0 ||
        ReadData_o !== 32'd0 || ALUdata_o !== 32'd0 || RegAddr_o !== 5'd0) begin
      errors++;
      $display("FAIL rst_wait: got req=%b stall=%b valid=%b err=%b rdata=%h alu=%h want all 0",
               dmem_req_o, stall_o, valid_o, err_o, ReadData_o, ALUdata_o);
    end
    @(posedge clk_i); #1;
    dmem_ack_i = 0;
    ALUdata_i = 32'd0;
    @(negedge clk_i);
    checks++;
    if (valid_o !== 1'b0 || ReadData_o !== 32'd0) begin
      errors++;
      $display("FAIL rst_late_ack: got valid=%b rdata=%h want 0 0", valid_o, ReadData_o);
    end
    $display("txn reset_mid_wait: late ack ignored check done");
  endtask

  task automatic test_back_to_back();
    do_op("b2b_pass", 2'd0, 2'd0, 1'b0, 1'b1, 32'h0, 32'h0000_0ABC, 5'd14, 0, 32'h0);
    do_op("b2b_rd0", 2'd3, 2'd0, 1'b0, 1'b1, 32'h0, 32'h0000_0400, 5'd15, 0, 32'h0102_0304);
    do_op("b2b_rd1", 2'd1, 2'd0, 1'b0, 1'b1, 32'h0, 32'h0000_0401, 5'd16, 0, 32'h0102_F304);
    do_op("b2b_wr", 2'd0, 2'd3, 1'b0, 1'b0, 32'h89AB_CDEF, 32'h0000_0404, 5'd0, 1, 32'h0);
  endtask

  initial begin
    set_idle();
    dmem_ack_i = 0;
    dmem_rdata_i = 32'h0;
    test_reset();
    test_passthrough();
    test_loads();
    test_stores();
    test_misalign();
    test_timeout();
    test_ack_idle();
    test_reset_mid_wait();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
